// File: rtl/ahb_mtx_err_slave.sv
// AHB error slave: answers every accepted transfer with a two-cycle ERROR, keeps a
// saturating error count and IRQ. Define AHB_MTX_ERR_CAPTURE_EN to add first-error capture.
module ahb_mtx_err_slave #(
  parameter int NUM_SEL     = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_WIDTH   = 8,
  localparam int SEL_W      = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_SEL-1:0]    HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  input  logic                  ERR_CLR,
  output logic [CNT_WIDTH-1:0]  ERR_COUNT,
  output logic                  ERR_IRQ
`ifdef AHB_MTX_ERR_CAPTURE_EN
  ,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  output logic [SEL_W-1:0]      ERR_SEL_ID,
  output logic                  ERR_WRITE
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t               state_reg;
  logic [3:0]           wait_cnt_reg;
  logic                 hreadyout_reg;
  logic [1:0]           hresp_reg;
  logic [CNT_WIDTH-1:0] err_count_reg;
  logic                 err_irq_reg;

  logic accept;
  logic addr_phase;
  logic err1_entry;
  logic cnt_full;
  logic unused_ok;

  assign accept     = HREADY & (|HSEL) & HTRANS[1];
  assign addr_phase = (state_reg == IDLE) || (state_reg == ERR2);
  assign err1_entry = (addr_phase && accept && (WAIT_LOAD == 4'd0)) ||
                      ((state_reg == WAIT) && (wait_cnt_reg == 4'd1));
  assign cnt_full   = &err_count_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= RESP_OKAY;
    end else begin
      case (state_reg)
        IDLE, ERR2: begin
          if (accept) begin
            hreadyout_reg <= 1'b0;
            if (WAIT_LOAD == 4'd0) begin
              state_reg    <= ERR1;
              wait_cnt_reg <= 4'd0;
              hresp_reg    <= RESP_ERROR;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_LOAD;
              hresp_reg    <= RESP_OKAY;
            end
          end else begin
            state_reg     <= IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= RESP_OKAY;
          end
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (wait_cnt_reg == 4'd1) begin
            state_reg <= ERR1;
            hresp_reg <= RESP_ERROR;
          end
        end
        ERR1: begin
          state_reg     <= ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= RESP_ERROR;
        end
        default: begin
          state_reg     <= IDLE;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= RESP_OKAY;
        end
      endcase
    end
  end

  // A clear coinciding with a new error leaves that error counted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_count_reg <= '0;
      err_irq_reg   <= 1'b0;
    end else begin
      err_irq_reg <= |err_count_reg;
      if (ERR_CLR) begin
        err_count_reg <= err1_entry ? CNT_WIDTH'(1) : '0;
      end else if (err1_entry && !cnt_full) begin
        err_count_reg <= err_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;
  assign ERR_COUNT = err_count_reg;
  assign ERR_IRQ   = err_irq_reg;

`ifdef AHB_MTX_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] pend_addr_reg;
  logic [SEL_W-1:0]      pend_id_reg;
  logic                  pend_write_reg;
  logic [ADDR_WIDTH-1:0] cap_addr_reg;
  logic [SEL_W-1:0]      cap_id_reg;
  logic                  cap_write_reg;
  logic [SEL_W-1:0]      sel_id;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [SEL_W-1:0]      src_id;
  logic                  src_write;

  // HSEL is one-hot, so OR-ing the indices of set bits yields the encoded index.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (HSEL[i]) sel_id = sel_id | SEL_W'(i);
    end
  end

  // With wait states the error lands cycles after the address phase, so use the held copy.
  assign src_addr  = (state_reg == WAIT) ? pend_addr_reg  : HADDR;
  assign src_id    = (state_reg == WAIT) ? pend_id_reg    : sel_id;
  assign src_write = (state_reg == WAIT) ? pend_write_reg : HWRITE;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_addr_reg  <= '0;
      pend_id_reg    <= '0;
      pend_write_reg <= 1'b0;
      cap_addr_reg   <= '0;
      cap_id_reg     <= '0;
      cap_write_reg  <= 1'b0;
    end else begin
      if (addr_phase && accept) begin
        pend_addr_reg  <= HADDR;
        pend_id_reg    <= sel_id;
        pend_write_reg <= HWRITE;
      end
      if (ERR_CLR) begin
        cap_addr_reg  <= err1_entry ? src_addr  : '0;
        cap_id_reg    <= err1_entry ? src_id    : '0;
        cap_write_reg <= err1_entry ? src_write : 1'b0;
      end else if (err1_entry && (err_count_reg == '0)) begin
        cap_addr_reg  <= src_addr;
        cap_id_reg    <= src_id;
        cap_write_reg <= src_write;
      end
    end
  end

  assign ERR_ADDR   = cap_addr_reg;
  assign ERR_SEL_ID = cap_id_reg;
  assign ERR_WRITE  = cap_write_reg;
  assign unused_ok  = &{1'b0, HTRANS[0]};
`else
  assign unused_ok  = &{1'b0, HTRANS[0], HADDR, HWRITE};
`endif

endmodule

// File: doc/ahb_mtx_err_slave.md
AHB_MTX_ERR_SLAVE -- requirements
Module: ahb_mtx_err_slave

Interface
REQ-001 SHALL provide parameter NUM_SEL, default 1, number of one-hot HSEL inputs (range 1-16).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, HADDR width.
REQ-003 SHALL provide parameter WAIT_STATES, default 0, wait cycles inserted before the ERROR response (range 0-15).
REQ-004 SHALL provide parameter CNT_WIDTH, default 8, error counter width.
REQ-005 SHALL have HCLK  input  1  AHB clock; reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-006 SHALL have HRESETn  input  1  asynchronous active-low reset.
REQ-007 SHALL have HSEL  input  NUM_SEL  per-region slave select, one-hot or zero.
REQ-008 SHALL have HADDR  input  ADDR_WIDTH  transfer address.
REQ-009 SHALL have HTRANS  input  2  transfer type.
REQ-010 SHALL have HWRITE  input  1  transfer direction.
REQ-011 SHALL have HREADY  input  1  bus transfer done.
REQ-012 SHALL have HREADYOUT  output  1  ready feedback.
REQ-013 SHALL have HRESP  output  2  response: 00 OKAY, 01 ERROR.
REQ-014 SHALL have ERR_CLR  input  1  synchronous clear of error status.
REQ-015 SHALL have ERR_COUNT  output  CNT_WIDTH  saturating error count.
REQ-016 SHALL have ERR_IRQ  output  1  registered, high while ERR_COUNT is non-zero.

Function
REQ-017 SHALL define accept = HREADY & (|HSEL) & HTRANS[1], sampled on the rising HCLK edge.
REQ-018 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=OKAY.
- WAIT: HREADYOUT=0, HRESP=OKAY.
- ERR1: HREADYOUT=0, HRESP=ERROR.
- ERR2: HREADYOUT=1, HRESP=ERROR.
REQ-019 SHALL, in IDLE on accept, go to WAIT with the wait counter loaded to WAIT_STATES; if WAIT_STATES=0, it SHALL go directly to ERR1.
REQ-020 SHALL decrement the wait counter each cycle in WAIT and go to ERR1 after exactly WAIT_STATES WAIT cycles.
REQ-021 SHALL go from ERR1 to ERR2 unconditionally.
REQ-022 SHALL, in ERR2, treat accept as a new transfer (back-to-back error) and follow the REQ-019 branching; otherwise it SHALL go to IDLE.
REQ-023 SHALL respond to IDLE/BUSY transfers (HTRANS[1]=0) and unselected cycles with zero-wait OKAY, with no state change.
REQ-024 SHALL ignore accept in WAIT and ERR1 (HREADY is low by protocol).
REQ-025 SHALL increment ERR_COUNT by 1 on each entry to ERR1, saturating at all-ones (no wrap).
REQ-026 SHALL clear ERR_COUNT to 0 when ERR_CLR=1; a simultaneous ERR_CLR and ERR1 entry SHALL yield ERR_COUNT=1.
REQ-027 SHALL register ERR_IRQ one cycle after ERR_COUNT changes, i.e. ERR_IRQ(n+1) = (ERR_COUNT(n) != 0).

Reset
REQ-028 SHALL, on HRESETn low, immediately set FSM=IDLE, wait counter=0, HREADYOUT=1, HRESP=OKAY, ERR_COUNT=0, ERR_IRQ=0, and all capture registers to 0, including mid-WAIT or mid-ERR1.
REQ-029 SHALL return to normal operation on the first HCLK edge after HRESETn deasserts.

Configuration
REQ-030 SHALL, with AHB_MTX_ERR_CAPTURE_EN defined, add outputs ERR_ADDR (ADDR_WIDTH), ERR_SEL_ID (clog2(NUM_SEL), minimum 1), and ERR_WRITE (1).
- On ERR1 entry while ERR_COUNT=0, these SHALL latch HADDR, the index of the set HSEL bit, and HWRITE as sampled at accept.
- This captures the first error only; later errors SHALL NOT overwrite the captured values until ERR_CLR is asserted.
- ERR_CLR SHALL zero the captured values; a simultaneous ERR_CLR and new error SHALL capture the new error.
REQ-031 SHALL, without AHB_MTX_ERR_CAPTURE_EN, omit these ports and registers entirely; all other behaviour SHALL be unchanged.

Verification
REQ-032 SHALL check: WAIT_STATES=0, NONSEQ with HSEL=1 -> HREADYOUT 0 then 1, HRESP ERROR for 2 cycles, ERR_COUNT=1, ERR_IRQ=1 one cycle later.
REQ-033 SHALL check: WAIT_STATES=3 -> 3 cycles of HREADYOUT=0/OKAY, then the 2-cycle ERROR, so HREADYOUT is low for 4 cycles in total.
REQ-034 SHALL check: back-to-back NONSEQ accepted in ERR2 -> second error with no IDLE cycle, ERR_COUNT=2.
REQ-035 SHALL check: CNT_WIDTH=2 with 5 errors -> ERR_COUNT holds 3; ERR_CLR coincident with an ERR1 entry -> ERR_COUNT=1.
REQ-036 SHALL check: with CAPTURE_EN, NUM_SEL=4, errors at HSEL=0100/HADDR=0x2000_0010/write, then HSEL=0001/0x0 -> ERR_ADDR=0x2000_0010, ERR_SEL_ID=2, ERR_WRITE=1.
REQ-037 SHALL check: HRESETn asserted during WAIT -> HREADYOUT=1, HRESP=OKAY, and ERR_COUNT=0 immediately; IDLE/BUSY transfers -> OKAY with no wait.
